// File: rtl/soc_noc_packet_receiver.sv
// Store-and-forward NoC packet sink: flits are buffered speculatively and a packet
// becomes visible downstream only once its last flit has been committed.
module soc_noc_packet_receiver #(
  parameter int FLIT_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int MAX_PKT_LEN = 8,
  parameter int DEST_WIDTH  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_WIDTH-1:0]    in_flit,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [FLIT_WIDTH-1:0]    out_flit,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DEST_WIDTH-1:0]    out_dest,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic [7:0]               drop_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t                  r_state;
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_cm_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [LW-1:0]           r_len;
  logic [PW-1:0]           r_pkt_count;
  logic [7:0]              r_drop_count;
  logic                    r_overflow;
  logic                    r_at_head;
  logic [DEST_WIDTH-1:0]   r_dest_hold;
  logic [FLIT_WIDTH:0]     r_mem [DEPTH];

  logic [PW-1:0]           w_fill_spec;
  logic [LW-1:0]           w_len_next;
  logic [FLIT_WIDTH:0]     w_rd_entry;
  logic                    w_in_fire;
  logic                    w_out_fire;
  logic                    w_store;
  logic                    w_commit;
  logic                    w_pkt_done;

  assign w_fill_spec = r_wr_ptr - r_rd_ptr;
  assign w_len_next  = r_len + LW'(1);
  assign w_rd_entry  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = out_valid && out_ready;
  assign w_store     = w_in_fire && (r_state != DROP);
  assign w_commit    = w_store && in_last;
  assign w_pkt_done  = w_out_fire && w_rd_entry[FLIT_WIDTH];

  // Space is judged on the pre-read fill; a read in the same cycle frees room only next cycle.
  assign in_ready   = !rst && ((r_state == DROP) || (w_fill_spec < PW'(DEPTH)));
  assign out_valid  = (r_pkt_count != '0);
  assign out_flit   = w_rd_entry[FLIT_WIDTH-1:0];
  assign out_last   = w_rd_entry[FLIT_WIDTH];
  assign out_dest   = r_at_head ? w_rd_entry[FLIT_WIDTH-1 -: DEST_WIDTH] : r_dest_hold;
  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;
  assign overflow   = r_overflow;

  // NOTE: the flit store has no reset; pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr[AW-1:0]] <= {in_last, in_flit};
  end

  // NOTE: all state updates use <= so every branch sees the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_cm_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_len        <= '0;
      r_pkt_count  <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
      r_at_head    <= 1'b1;
      r_dest_hold  <= '0;
    end else begin
      case (r_state)
        IDLE, RECV: begin
          if (w_in_fire) begin
            if (in_last) begin
              r_wr_ptr <= r_wr_ptr + PW'(1);
              r_cm_ptr <= r_wr_ptr + PW'(1);
              r_len    <= '0;
              r_state  <= IDLE;
            end else if (w_len_next == LW'(MAX_PKT_LEN)) begin
              // Oversized packet: rewind to the commit point and swallow the rest.
              r_wr_ptr <= r_cm_ptr;
              r_len    <= '0;
              r_state  <= DROP;
            end else begin
              r_wr_ptr <= r_wr_ptr + PW'(1);
              r_len    <= w_len_next;
              r_state  <= RECV;
            end
          end
        end
        DROP: begin
          if (w_in_fire && in_last) begin
            if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
            r_overflow <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_out_fire) begin
        r_rd_ptr  <= r_rd_ptr + PW'(1);
        r_at_head <= w_rd_entry[FLIT_WIDTH];
        if (r_at_head) r_dest_hold <= w_rd_entry[FLIT_WIDTH-1 -: DEST_WIDTH];
      end

      case ({w_commit, w_pkt_done})
        2'b10:   r_pkt_count <= r_pkt_count + PW'(1);
        2'b01:   r_pkt_count <= r_pkt_count - PW'(1);
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_noc_packet_receiver.sv
// Directed bench for soc_noc_packet_receiver: hand-computed packets, a negedge output
// monitor feeding a queue, and a single check task for every comparison.
module tb_soc_noc_packet_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_flit;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_flit;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_dest;
  logic [4:0]  pkt_count;
  logic [7:0]  drop_count;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt = 0;
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  always #5 clk = ~clk;

  soc_noc_packet_receiver #(
    .FLIT_WIDTH(32), .DEPTH(16), .MAX_PKT_LEN(8), .DEST_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_dest(out_dest), .pkt_count(pkt_count), .drop_count(drop_count), .overflow(overflow)
  );

  always @(negedge clk)
    if (!rst && out_valid && out_ready) got_q.push_back({out_last, out_flit});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents one flit and holds it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] d, input logic l);
    int waited = 0;
    in_valid = 1'b1; in_flit = d; in_last = l;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    stall_cnt += waited;
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    @(negedge clk);
    while (pkt_count != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (pkt_count != 0) check({tag, "_drain_timeout"}, 64'(pkt_count), 64'd0);
    step();
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_flit%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_flit = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    step();

    // 3-flit packet, out_ready already high
    out_ready = 1'b1;
    send(32'hA000_0001, 1'b0);
    send(32'h0000_0002, 1'b0);
    in_valid = 1'b1; in_flit = 32'h0000_0003; in_last = 1'b1;
    @(negedge clk);
    check("p3_valid_during_last", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("p3_valid_next", 64'(out_valid), 64'd1);
    check("p3_dest", 64'(out_dest), 64'h14);
    check("p3_pkt_count1", 64'(pkt_count), 64'd1);
    check("p3_head", 64'(out_flit), 64'hA000_0001);
    @(negedge clk);
    check("p3_pkt_count_mid", 64'(pkt_count), 64'd1);
    @(negedge clk);
    check("p3_last_flag", 64'(out_last), 64'd1);
    @(negedge clk);
    check("p3_pkt_count0", 64'(pkt_count), 64'd0);
    check("p3_valid_low", 64'(out_valid), 64'd0);
    exp_q.push_back({1'b0, 32'hA000_0001});
    exp_q.push_back({1'b0, 32'h0000_0002});
    exp_q.push_back({1'b1, 32'h0000_0003});
    step();
    compare_stream("p3");

    // single-flit packet
    out_ready = 1'b0;
    send(32'h0800_0000, 1'b1);
    @(negedge clk);
    check("p1_pkt_count", 64'(pkt_count), 64'd1);
    check("p1_valid", 64'(out_valid), 64'd1);
    check("p1_dest", 64'(out_dest), 64'd1);
    check("p1_last", 64'(out_last), 64'd1);
    check("p1_flit", 64'(out_flit), 64'h0800_0000);
    step();
    out_ready = 1'b1;
    exp_q.push_back({1'b1, 32'h0800_0000});
    drain("p1");
    compare_stream("p1");

    // reset with one complete packet buffered and another two flits in
    out_ready = 1'b0;
    send(32'h4000_0010, 1'b0);
    send(32'h4000_0011, 1'b1);
    send(32'h4000_0012, 1'b0);
    send(32'h4000_0013, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
    check("mid_rst_drop_count", 64'(drop_count), 64'd0);
    check("mid_rst_in_ready_after", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b1;
    send(32'h5000_0020, 1'b0);
    send(32'h5000_0021, 1'b1);
    exp_q.push_back({1'b0, 32'h5000_0020});
    exp_q.push_back({1'b1, 32'h5000_0021});
    drain("after_rst");
    compare_stream("after_rst");

    // 10-flit oversize packet, then a 2-flit and an exactly-MAX 8-flit packet
    out_ready = 1'b1;
    stall_cnt = 0;
    for (int k = 0; k < 10; k++) send(32'h6000_0000 + 32'(k), k == 9);
    @(negedge clk);
    check("drop_no_stall", 64'(stall_cnt), 64'd0);
    check("drop_count1", 64'(drop_count), 64'd1);
    check("drop_overflow", 64'(overflow), 64'd1);
    check("drop_no_output", 64'(got_q.size()), 64'd0);
    check("drop_pkt_count", 64'(pkt_count), 64'd0);
    step();
    send(32'h1111_0000, 1'b0);
    send(32'h2222_0001, 1'b1);
    exp_q.push_back({1'b0, 32'h1111_0000});
    exp_q.push_back({1'b1, 32'h2222_0001});
    for (int k = 0; k < 8; k++) begin
      send(32'h9000_0000 + 32'(k), k == 7);
      exp_q.push_back({k == 7, 32'h9000_0000 + 32'(k)});
    end
    drain("post_drop");
    compare_stream("post_drop");
    check("max_len_not_dropped", 64'(drop_count), 64'd1);

    // fill the buffer with four 4-flit packets, then release and add a fifth
    out_ready = 1'b0;
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 4; k++) begin
        send(32'h7000_0000 + 32'(p * 16 + k), k == 3);
        exp_q.push_back({k == 3, 32'h7000_0000 + 32'(p * 16 + k)});
      end
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_pkt_count", 64'(pkt_count), 64'd4);
    check("full_out_valid", 64'(out_valid), 64'd1);
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(32'h7000_0040 + 32'(k), k == 3);
      exp_q.push_back({k == 3, 32'h7000_0040 + 32'(k)});
    end
    drain("full");
    compare_stream("full");

    // commit of B in the same cycle as the final read of A
    out_ready = 1'b0;
    send(32'h8000_00A0, 1'b0);
    send(32'h8000_00A1, 1'b1);
    send(32'h8000_00B0, 1'b0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b1; in_flit = 32'h8000_00B1; in_last = 1'b1;
    @(negedge clk);
    check("overlap_in_ready", 64'(in_ready), 64'd1);
    check("overlap_a_last", 64'(out_last), 64'd1);
    check("overlap_pkt_before", 64'(pkt_count), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("overlap_pkt_after", 64'(pkt_count), 64'd1);
    check("overlap_no_gap", 64'(out_valid), 64'd1);
    check("overlap_b_head", 64'(out_flit), 64'h8000_00B0);
    exp_q.push_back({1'b0, 32'h8000_00A0});
    exp_q.push_back({1'b1, 32'h8000_00A1});
    exp_q.push_back({1'b0, 32'h8000_00B0});
    exp_q.push_back({1'b1, 32'h8000_00B1});
    step();
    drain("overlap");
    compare_stream("overlap");

    // drop counter saturates at 255
    for (int d = 0; d < 255; d++)
      for (int k = 0; k < 9; k++) send(32'(k), k == 8);
    @(negedge clk);
    check("drop_saturate", 64'(drop_count), 64'd255);
    check("drop_sat_overflow", 64'(overflow), 64'd1);
    check("drop_sat_pkt_count", 64'(pkt_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
